// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive FIFO words into one wide beat on a valid/ready stream.
// A flush closes the current partial beat early and tags it with out_last.
module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4,
  parameter int CNTW  = $clog2(RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_pop,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [CNTW-1:0]        out_count,
  output logic                   out_last
);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(RATIO);

  logic [WIDTH*RATIO-1:0] acc_q, acc_d;
  logic [CNTW-1:0]        acc_cnt_q, acc_cnt_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH*RATIO-1:0] out_data_q, out_data_d;
  logic [CNTW-1:0]        out_count_q, out_count_d;
  logic                   out_last_q, out_last_d;
  logic                   slot_free;
  logic                   xfer;
  logic                   pop;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    xfer      = slot_free && ((acc_cnt_q == FULL_CNT) || (flush_pend_q && (acc_cnt_q != '0)));
    pop       = !rst && !fifo_empty && !flush && !flush_pend_q &&
                ((acc_cnt_q < FULL_CNT) || xfer);
  end

  assign fifo_pop = pop;

  always_comb begin
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q;
      out_count_d = acc_cnt_q;
      out_last_d  = flush_pend_q;
      acc_d       = '0;
      acc_cnt_d   = '0;
    end

    // A pop that coincides with a transfer starts the fresh accumulator at slot 0.
    if (pop) begin
      if (xfer) begin
        acc_d[WIDTH-1:0] = fifo_data;
        acc_cnt_d        = CNTW'(1);
      end else begin
        for (int k = 0; k < RATIO; k++) begin
          if (acc_cnt_q == CNTW'(k)) begin
            acc_d[k*WIDTH +: WIDTH] = fifo_data;
          end
        end
        acc_cnt_d = acc_cnt_q + CNTW'(1);
      end
    end

    // Repeat flushes merge into the pending one; an empty accumulator drops it.
    if (flush_pend_q) begin
      if (xfer || (acc_cnt_q == '0)) begin
        flush_pend_d = 1'b0;
      end
    end else begin
      flush_pend_d = flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a source queue plays the FIFO, a word-group
// model predicts beats, and a negedge monitor compares every accepted beat.
module tb_fifo_word_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int CNTW  = $clog2(RATIO) + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   fifo_empty = 1'b1;
  logic [WIDTH-1:0]       fifo_data = '0;
  logic                   fifo_pop;
  logic                   flush = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [CNTW-1:0]        out_count;
  logic                   out_last;

  fifo_word_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH*RATIO-1:0] data;
    int                     cnt;
    bit                     last;
  } beat_t;

  beat_t                  exp_q[$];
  logic [WIDTH-1:0]       src[$];
  int                     open_n = 0;
  logic [WIDTH*RATIO-1:0] open_data = '0;
  int                     checks = 0;
  int                     errors = 0;
  int                     beats_seen = 0;
  bit                     gap_en = 1'b0;
  bit                     hold_valid = 1'b0;
  logic [WIDTH*RATIO-1:0] hold_data;
  logic [CNTW-1:0]        hold_count;
  logic                   hold_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO side: present the head of the source queue just after each edge.
  always begin
    @(posedge clk);
    #2;
    fifo_empty = (src.size() == 0) || (gap_en && ($urandom_range(0, 3) == 0));
    fifo_data  = (src.size() != 0) ? src[0] : '0;
  end

  // Monitor: feed the model from pops/flushes and check each accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      open_n     = 0;
      open_data  = '0;
      hold_valid = 1'b0;
    end else begin
      if (flush) chk("pop_during_flush", {63'd0, fifo_pop}, 64'd0);
      if (fifo_pop) begin
        open_data = open_data | ({{(WIDTH*(RATIO-1)){1'b0}}, fifo_data} << (WIDTH * open_n));
        open_n++;
        if (src.size() != 0) void'(src.pop_front());
        if (open_n == RATIO) begin
          exp_q.push_back('{data: open_data, cnt: RATIO, last: 1'b0});
          open_n    = 0;
          open_data = '0;
        end
      end
      if (flush && open_n > 0) begin
        exp_q.push_back('{data: open_data, cnt: open_n, last: 1'b1});
        open_n    = 0;
        open_data = '0;
      end
      if (out_valid) begin
        chk("count_nonzero", {63'd0, out_count != '0}, 64'd1);
        if (hold_valid) begin
          chk("hold_data", 64'(out_data), 64'(hold_data));
          chk("hold_count", 64'(out_count), 64'(hold_count));
          chk("hold_last", {63'd0, out_last}, {63'd0, hold_last});
        end
        if (out_ready) begin
          beats_seen++;
          hold_valid = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h expected no beat", out_data);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            $display("beat %0d: data=0x%08h count=%0d last=%0d", beats_seen, out_data, out_count, out_last);
            chk("beat_data", 64'(out_data), 64'(e.data));
            chk("beat_count", 64'(out_count), 64'(e.cnt));
            chk("beat_last", {63'd0, out_last}, {63'd0, e.last});
          end
        end else begin
          hold_valid = 1'b1;
          hold_data  = out_data;
          hold_count = out_count;
          hold_last  = out_last;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      done = (src.size() == 0) && (exp_q.size() == 0) && !out_valid;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: timeout with %0d words and %0d beats outstanding, required 0", name, src.size(), exp_q.size());
    end
  endtask

  initial begin
    int b0;
    // Reset state with words already available.
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33); src.push_back(8'h44);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pop", {63'd0, fifo_pop}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);

    // First full beat and its latency.
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_pop", {63'd0, fifo_pop}, 64'd1);
    end
    @(negedge clk);
    chk("t1_pop_after", {63'd0, fifo_pop}, 64'd0);
    chk("t1_valid_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_data", 64'(out_data), 64'h44332211);
    chk("t1_count", 64'(out_count), 64'd4);
    chk("t1_last", {63'd0, out_last}, 64'd0);
    wait_idle("t1_drain", 50);

    // Continuous stream: pop never drops.
    b0 = beats_seen;
    for (int i = 0; i < 12; i++) src.push_back(8'(8'h50 + i));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2_pop", {63'd0, fifo_pop}, 64'd1);
    end
    wait_idle("t2_drain", 50);
    chk("t2_beats", 64'(beats_seen - b0), 64'd3);

    // Backpressure: accumulator fills behind a held beat.
    b0 = beats_seen;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) src.push_back(8'(8'h70 + i));
    repeat (20) tick();
    @(negedge clk);
    chk("t3_pop_blocked", {63'd0, fifo_pop}, 64'd0);
    chk("t3_valid_held", {63'd0, out_valid}, 64'd1);
    chk("t3_src_left", 64'(src.size()), 64'd4);
    tick();
    out_ready = 1'b1;
    wait_idle("t3_drain", 60);
    chk("t3_beats", 64'(beats_seen - b0), 64'd3);

    // Flush of a two-word partial beat.
    src.push_back(8'hAA); src.push_back(8'hBB);
    wait_idle("t4_fill", 20);
    flush = 1'b1;
    src.push_back(8'hCC);
    @(negedge clk);
    chk("t4_pop_flush", {63'd0, fifo_pop}, 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_pop_pend", {63'd0, fifo_pop}, 64'd0);
    @(negedge clk);
    chk("t4_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_data", 64'(out_data), 64'h0000BBAA);
    chk("t4_count", 64'(out_count), 64'd2);
    chk("t4_last", {63'd0, out_last}, 64'd1);
    chk("t4_pop_resume", {63'd0, fifo_pop}, 64'd1);
    src.push_back(8'hDD); src.push_back(8'hEE); src.push_back(8'hFF);
    wait_idle("t4_drain", 40);

    // Flush with an empty accumulator emits nothing.
    repeat (3) tick();
    flush = 1'b1;
    src.push_back(8'h5A);
    @(negedge clk);
    chk("t5_pop_flush", {63'd0, fifo_pop}, 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_pop_pend", {63'd0, fifo_pop}, 64'd0);
    chk("t5_no_beat", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("t5_pop_resume", {63'd0, fifo_pop}, 64'd1);
    chk("t5_no_beat2", {63'd0, out_valid}, 64'd0);
    src.push_back(8'h5B); src.push_back(8'h5C); src.push_back(8'h5D);
    wait_idle("t5_drain", 40);

    // Reset mid-operation with a held beat and three words in the accumulator.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) src.push_back(8'(8'h90 + i));
    repeat (15) tick();
    chk("t6_pre_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    flush = 1'b1;
    src.push_back(8'hC1); src.push_back(8'hC2); src.push_back(8'hC3); src.push_back(8'hC4);
    @(negedge clk);
    chk("t6_rst_pop", {63'd0, fifo_pop}, 64'd0);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_data", 64'(out_data), 64'd0);
    chk("t6_count", 64'(out_count), 64'd0);
    chk("t6_last", {63'd0, out_last}, 64'd0);
    chk("t6_pop", {63'd0, fifo_pop}, 64'd1);
    wait_idle("t6_drain", 40);

    // Randomized traffic with gaps, backpressure and partial flushes.
    gap_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (src.size() < 6) src.push_back(8'($urandom));
      flush = (open_n > 0) && (open_n < RATIO) && ($urandom_range(0, 7) == 0);
    end
    tick();
    flush = 1'b0;
    gap_en = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_drain", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
